// File: rtl/pkt_router_nport.sv
// Store-and-forward byte packet router with NUM_PORTS ready/valid outputs.
// Ports: clk, reset (sync, active-high); dut_inp/inp_valid byte input;
//   dut_outp shared output byte, outp_valid one-hot, outp_ready per port;
//   busy, error (last verdict), pkt_in/out/drop_cnt statistics.
module pkt_router_nport #(
  parameter int NUM_PORTS = 4,
  parameter int MIN_PKT   = 12,
  parameter int MAX_PKT   = 2000,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           dut_inp,
  input  logic                 inp_valid,
  output logic [7:0]           dut_outp,
  output logic [NUM_PORTS-1:0] outp_valid,
  input  logic [NUM_PORTS-1:0] outp_ready,
  output logic                 busy,
  output logic [3:0]           error,
  output logic [CNT_W-1:0]     pkt_in_cnt,
  output logic [CNT_W-1:0]     pkt_out_cnt,
  output logic [CNT_W-1:0]     pkt_drop_cnt
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(MAX_PKT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_SEND,
    S_DISCARD
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [MAX_PKT];
  logic [31:0]     r_cnt;
  logic [31:0]     r_len;
  logic [31:0]     r_crc;
  logic [31:0]     r_sum;
  logic [7:0]      r_da;
  logic [PW-1:0]   r_port;
  logic [AW-1:0]   r_rd_idx;
  logic            r_out_on;
  logic            r_shadow;

  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;
  logic [3:0]      w_verdict;
  logic [NUM_PORTS-1:0] w_port_oh;
  logic            w_accept;
  logic            w_last;
  logic [AW-1:0]   w_nxt_idx;
  logic            w_run_end;

  // Oversize bytes are counted but never stored.
  assign w_wr_en = inp_valid &&
    ((r_state == S_IDLE) ||
     ((r_state == S_RECV) && (r_cnt < 32'(MAX_PKT))));
  assign w_wr_addr = (r_state == S_IDLE) ? '0 : r_cnt[AW-1:0];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= dut_inp;
  end

  // First failing check wins; LEN mismatch is checked before size.
  always_comb begin
    w_verdict = 4'd0;
    if (r_len != r_cnt)                      w_verdict = 4'd5;
    else if (r_cnt < 32'(MIN_PKT))           w_verdict = 4'd3;
    else if (r_cnt > 32'(MAX_PKT))           w_verdict = 4'd4;
    else if ({24'd0, r_da} >= 32'(NUM_PORTS)) w_verdict = 4'd6;
    else if (r_crc != r_sum)                 w_verdict = 4'd2;
  end

  assign w_port_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_port;
  assign w_accept  = r_out_on && outp_ready[r_port];
  assign w_last    = ({{(32-AW){1'b0}}, r_rd_idx} == (r_cnt - 32'd1));
  assign w_nxt_idx = r_rd_idx + AW'(1);
  assign w_run_end = r_shadow && !inp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_crc        <= '0;
      r_sum        <= '0;
      r_da         <= '0;
      r_port       <= '0;
      r_rd_idx     <= '0;
      r_out_on     <= 1'b0;
      r_shadow     <= 1'b0;
      dut_outp     <= '0;
      outp_valid   <= '0;
      busy         <= 1'b0;
      error        <= '0;
      pkt_in_cnt   <= '0;
      pkt_out_cnt  <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (inp_valid) begin
            error   <= '0;
            r_cnt   <= 32'd1;
            r_da    <= dut_inp;
            r_len   <= '0;
            r_crc   <= '0;
            r_sum   <= '0;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (inp_valid) begin
            r_cnt <= r_cnt + 32'd1;
            case (r_cnt)
              32'd2: r_len[31:24] <= dut_inp;
              32'd3: r_len[23:16] <= dut_inp;
              32'd4: r_len[15:8]  <= dut_inp;
              32'd5: r_len[7:0]   <= dut_inp;
              32'd6: r_crc[31:24] <= dut_inp;
              32'd7: r_crc[23:16] <= dut_inp;
              32'd8: r_crc[15:8]  <= dut_inp;
              32'd9: r_crc[7:0]   <= dut_inp;
              default: ;
            endcase
            if (r_cnt >= 32'd10)
              r_sum <= r_sum + {24'd0, dut_inp};
          end else begin
            pkt_in_cnt <= pkt_in_cnt + 1'b1;
            if (w_verdict != 4'd0) begin
              error        <= w_verdict;
              pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
              r_state      <= S_IDLE;
            end else begin
              busy     <= 1'b1;
              r_port   <= r_da[PW-1:0];
              r_rd_idx <= '0;
              r_out_on <= 1'b0;
              r_shadow <= 1'b0;
              r_state  <= S_SEND;
            end
          end
        end
        S_SEND: begin
          // Input arriving mid-send is swallowed in the background.
          if (inp_valid && !r_shadow) begin
            r_shadow <= 1'b1;
            error    <= 4'd1;
          end
          if (w_run_end) begin
            r_shadow     <= 1'b0;
            pkt_in_cnt   <= pkt_in_cnt + 1'b1;
            pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
          end
          if (!r_out_on) begin
            r_out_on   <= 1'b1;
            outp_valid <= w_port_oh;
            dut_outp   <= r_mem[0];
          end else if (w_accept) begin
            if (w_last) begin
              r_out_on    <= 1'b0;
              outp_valid  <= '0;
              dut_outp    <= '0;
              busy        <= 1'b0;
              pkt_out_cnt <= pkt_out_cnt + 1'b1;
              r_state     <= inp_valid ? S_DISCARD : S_IDLE;
            end else begin
              r_rd_idx <= w_nxt_idx;
              dut_outp <= r_mem[w_nxt_idx];
            end
          end
        end
        S_DISCARD: begin
          if (!inp_valid) begin
            pkt_in_cnt   <= pkt_in_cnt + 1'b1;
            pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
            r_shadow     <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
